ir_err_gen: RTL

Producer side of the PID error path. It sequences the eight IR line-sensor conversions through the shared A2D, forms a weighted left/right error, and arithmetic-shifts it. It then saturates the result to 11-bit signed and presents it as `err_sat` with a one-cycle `err_vld` strobe, plus `line_present`. These feed the I-term integrator and the other PID terms.

---
 rtl/ir_err_gen.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/ir_err_gen.sv
// ir_err_gen: sequences the eight IR line-sensor conversions through the shared
// A2D, forms a weighted right-minus-left error, shifts it down by 4 and saturates
// it to 11-bit signed for the PID error path.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   go            enable; low aborts any round and holds the block idle
//   cnv_cmplt     A2D conversion-done pulse
//   res[11:0]     A2D result (unsigned), valid with cnv_cmplt
//   strt_cnv      one-cycle A2D start request
//   chnnl[2:0]    A2D channel select, stable from strt_cnv to cnv_cmplt
//   IR_en         IR emitter enable
//   err_sat[10:0] saturated signed error
//   err_vld       one-cycle strobe: err_sat / line_present updated
//   line_present  some reading in the last completed round exceeded LINE_THRES
module ir_err_gen #(
    parameter int unsigned PERIOD     = 4096,
    parameter int unsigned SETTLE_CYC = 256,
    parameter logic [11:0] LINE_THRES = 12'h400
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        go,
    input  logic        cnv_cmplt,
    input  logic [11:0] res,
    output logic        strt_cnv,
    output logic [2:0]  chnnl,
    output logic        IR_en,
    output logic [10:0] err_sat,
    output logic        err_vld,
    output logic        line_present
);

    localparam int unsigned PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int unsigned SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int unsigned AW = 18;
    localparam int unsigned TW = 14;

    localparam logic [PW-1:0] PRD_MAX    = PW'(PERIOD - 1);
    localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE_CYC - 1);

    localparam logic signed [TW-1:0] T_MAX = 14'sd1023;
    localparam logic signed [TW-1:0] T_MIN = -14'sd1024;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SETTLE = 3'd1;
    localparam logic [2:0] REQ    = 3'd2;
    localparam logic [2:0] WAIT   = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    logic [2:0]           state, state_nxt;
    logic [PW-1:0]        prd, prd_nxt;
    logic [SW-1:0]        settle, settle_nxt;
    logic signed [AW-1:0] acc, acc_nxt;
    logic                 line, line_nxt;
    logic [2:0]           chnnl_nxt;
    logic                 strt_nxt, ir_en_nxt, vld_nxt, lp_nxt;
    logic [10:0]          err_nxt;

    logic                 start;
    logic [AW-1:0]        mag;
    logic signed [TW-1:0] t;
    logic [10:0]          sat;

    // Round may start only from IDLE once the period counter has saturated.
    assign start = (state == IDLE) && go && (prd == PRD_MAX);

    // Reading weighted by its pair index; sign applied at accumulation.
    assign mag = AW'(res) << chnnl[2:1];

    // acc >>> 4 taken as a slice keeps the floor semantics of the shift.
    assign t   = acc[AW-1:4];
    assign sat = (t > T_MAX) ? 11'h3FF :
                 (t < T_MIN) ? 11'h400 : t[10:0];

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            prd          <= '0;
            settle       <= '0;
            acc          <= '0;
            line         <= 1'b0;
            chnnl        <= '0;
            strt_cnv     <= 1'b0;
            IR_en        <= 1'b0;
            err_sat      <= '0;
            err_vld      <= 1'b0;
            line_present <= 1'b0;
        end else begin
            state        <= state_nxt;
            prd          <= prd_nxt;
            settle       <= settle_nxt;
            acc          <= acc_nxt;
            line         <= line_nxt;
            chnnl        <= chnnl_nxt;
            strt_cnv     <= strt_nxt;
            IR_en        <= ir_en_nxt;
            err_sat      <= err_nxt;
            err_vld      <= vld_nxt;
            line_present <= lp_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt  = state;
        prd_nxt    = prd;
        settle_nxt = settle;
        acc_nxt    = acc;
        line_nxt   = line;
        chnnl_nxt  = chnnl;
        strt_nxt   = 1'b0;
        vld_nxt    = 1'b0;
        ir_en_nxt  = IR_en;
        err_nxt    = err_sat;
        lp_nxt     = line_present;

        if (!go || start) begin
            prd_nxt = '0;
        end else if (prd != PRD_MAX) begin
            prd_nxt = prd + PW'(1);
        end

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt  = SETTLE;
                    acc_nxt    = '0;
                    line_nxt   = 1'b0;
                    chnnl_nxt  = '0;
                    settle_nxt = '0;
                    ir_en_nxt  = 1'b1;
                end
            end
            SETTLE: begin
                if (settle == SETTLE_MAX) begin
                    state_nxt = REQ;
                    strt_nxt  = 1'b1;
                end else begin
                    settle_nxt = settle + SW'(1);
                end
            end
            REQ: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (cnv_cmplt) begin
                    acc_nxt  = chnnl[0] ? (acc + $signed(mag)) : (acc - $signed(mag));
                    line_nxt = line | (res > LINE_THRES);
                    if (chnnl == 3'd7) begin
                        state_nxt = DONE;
                    end else begin
                        chnnl_nxt = chnnl + 3'd1;
                        state_nxt = REQ;
                        strt_nxt  = 1'b1;
                    end
                end
            end
            DONE: begin
                err_nxt   = sat;
                lp_nxt    = line;
                vld_nxt   = 1'b1;
                ir_en_nxt = 1'b0;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                ir_en_nxt = 1'b0;
            end
        endcase

        // Abort: discard the round, keep the last published results.
        if (!go) begin
            state_nxt = IDLE;
            ir_en_nxt = 1'b0;
            strt_nxt  = 1'b0;
            vld_nxt   = 1'b0;
            err_nxt   = err_sat;
            lp_nxt    = line_present;
        end
    end

endmodule
